// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer-1 input sequencer.
// Contents:
//   N_WORDS     pixels per frame; trans_buf depth must equal this value
//   PIX_W       pixel width shared with normalize
//   CNT_W       width of the per-frame issue counter (holds 0..N_WORDS)
//   seq_state_t sequencer FSM state encoding
package layer_seq_pkg;

  localparam int N_WORDS = 884;
  localparam int PIX_W   = 8;
  localparam int CNT_W   = $clog2(N_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE,
    ERR
  } seq_state_t;

endpackage

// File: rtl/layer_seq_if.sv
// Bundle of host, source-memory and pipeline signals around layer_seq.
// Signals:
//   start, abort, frame_base          host control into the sequencer
//   busy, done, error, issued         host status out of the sequencer
//   src_avail, mem_en, mem_addr,
//   mem_rdata                         byte-wide source memory read port
//   pix_data, pix_valid               pixel stream into normalize
//   buf_valid                         trans_buf frame-complete strobe
// Modports:
//   master  the sequencer itself
//   slave   everything around it (host, memory, pipeline)
interface layer_seq_if #(
  parameter int ADDR_W = 16
);
  import layer_seq_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] frame_base;
  logic              src_avail;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              buf_valid;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  issued;

  modport master (
    input  start, abort, frame_base, src_avail, mem_rdata, buf_valid,
    output mem_en, mem_addr, pix_data, pix_valid, busy, done, error, issued
  );

  modport slave (
    output start, abort, frame_base, src_avail, mem_rdata, buf_valid,
    input  mem_en, mem_addr, pix_data, pix_valid, busy, done, error, issued
  );

endinterface

// File: rtl/layer_seq.sv
// Frame sequencer for the layer-1 input pipeline (normalize -> ftof -> trans_buf).
// On start it reads N_WORDS pixels from the source memory, streams them into
// the pipeline, then waits for trans_buf to report a full frame. A watchdog
// bounds the wait and parks the block in a sticky error state if it expires.
// Ports:
//   clk    single rising-edge clock
//   rst_n  asynchronous reset, active HIGH (historical name kept)
//   bus    layer_seq_if master modport (host, memory and pipeline signals)
// Parameters:
//   ADDR_W   source memory address width; must match the interface
//   TIMEOUT  DRAIN cycles allowed before error; >= pipeline latency + 1
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  layer_seq_if.master bus
);

  localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_WORDS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  idx;
  logic [WDOG_W-1:0] wdog;
  logic              pix_valid_q;
  logic              start_ok;
  logic              beat;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A memory beat is issued combinationally whenever the
  // source is available in ISSUE. Abort overrides the next state but not the
  // beat of the current cycle, so that beat's pixel still reaches the pipeline.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (bus.start) begin
          start_ok  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.src_avail) begin
          beat = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // buf_valid wins over an expiring watchdog on the same cycle.
        if (bus.buf_valid) begin
          state_nxt = DONE;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (bus.abort) begin
      state_nxt = IDLE;
      start_ok  = 1'b0;
    end
  end

  // Frame base, beat index (doubles as the issued count), drain watchdog and
  // the one-cycle valid delay that matches the memory read latency.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      base        <= '0;
      idx         <= '0;
      wdog        <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= beat;
      if (bus.abort) begin
        idx  <= '0;
        wdog <= '0;
      end else if (start_ok) begin
        base <= bus.frame_base;
        idx  <= '0;
        wdog <= '0;
      end else begin
        if (beat) begin
          idx <= idx + CNT_W'(1);
        end
        if (state == DRAIN) begin
          wdog <= wdog + WDOG_W'(1);
        end
      end
    end
  end

  // Address arithmetic wraps naturally at 2^ADDR_W.
  assign bus.mem_en    = beat;
  assign bus.mem_addr  = beat ? (base + ADDR_W'(idx)) : '0;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_valid_q ? bus.mem_rdata : '0;
  assign bus.busy      = (state == ISSUE) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.error     = (state == ERR);
  assign bus.issued    = idx;

endmodule
